// File: rtl/jam_cost_loader_if.sv
// Host cost stream for the job-assignment loader: one cost entry per valid/ready beat,
// with in_last flagging the final beat of a frame.
interface jam_cost_loader_if #(
   parameter int COST_W = 7
) ();
   logic              in_valid;
   logic              in_ready;
   logic [COST_W-1:0] in_data;
   logic              in_last;

   modport master (output in_valid, output in_data, output in_last, input in_ready);
   modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/jam_cost_loader.sv
// Loads an NxN cost table from the host stream, then releases the assignment solver
// and captures its MinCost/MatchCount, holding the result until the next frame begins.
module jam_cost_loader #(
   parameter int COST_W = 7,
   parameter int N      = 8
) (
   input  logic                       CLK,
   input  logic                       RST,
   jam_cost_loader_if.slave           host,
   input  logic [$clog2(N)-1:0]       W,
   input  logic [$clog2(N)-1:0]       J,
   output logic [COST_W-1:0]          Cost,
   output logic                       jam_rst,
   input  logic                       jam_valid,
   input  logic [9:0]                 jam_min,
   input  logic [3:0]                 jam_cnt,
   output logic                       res_valid,
   output logic [9:0]                 res_min,
   output logic [3:0]                 res_cnt,
   output logic                       busy,
   output logic                       err_len
);
   localparam int IDX_W = 2 * $clog2(N);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N * N - 1);

   typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              res_valid_q, res_valid_d;
   logic [9:0]        res_min_q, res_min_d;
   logic [3:0]        res_cnt_q, res_cnt_d;
   logic              err_q, err_d;
   logic              jam_rst_q, jam_rst_d;
   logic              wr_en;
   logic              accept;
   logic              frame_end;
   logic [COST_W-1:0] cost_q [N*N];

   assign accept    = host.in_valid && (state_q != S_RUN);
   assign frame_end = (idx_q == LAST_IDX);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_LOAD;
         idx_q       <= '0;
         res_valid_q <= 1'b0;
         res_min_q   <= '0;
         res_cnt_q   <= '0;
         err_q       <= 1'b0;
         jam_rst_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         res_valid_q <= res_valid_d;
         res_min_q   <= res_min_d;
         res_cnt_q   <= res_cnt_d;
         err_q       <= err_d;
         jam_rst_q   <= jam_rst_d;
      end
   end

   // NOTE: the cost table has no reset; its contents intentionally survive RST and are only rewritten by a frame.
   always_ff @(posedge CLK) begin
      if (wr_en) cost_q[idx_q] <= host.in_data;
   end

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      res_valid_d = res_valid_q;
      res_min_d   = res_min_q;
      res_cnt_d   = res_cnt_q;
      err_d       = err_q;
      wr_en       = 1'b0;
      unique case (state_q)
         S_LOAD, S_DONE: begin
            if (accept) begin
               wr_en       = !RST;
               res_valid_d = 1'b0;
               if (host.in_last != frame_end) begin
                  // Frame too short or too long: flag it and make the host start over.
                  err_d   = 1'b1;
                  idx_d   = '0;
                  state_d = S_LOAD;
               end else if (frame_end) begin
                  idx_d   = '0;
                  state_d = S_RUN;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = S_LOAD;
               end
            end
         end
         S_RUN: begin
            if (jam_valid) begin
               res_valid_d = 1'b1;
               res_min_d   = jam_min;
               res_cnt_d   = jam_cnt;
               state_d     = S_DONE;
            end
         end
         default: state_d = S_LOAD;
      endcase
      jam_rst_d = (state_d == S_LOAD);
   end

   always_comb begin
      host.in_ready = (state_q != S_RUN);
      busy          = (state_q == S_RUN);
      jam_rst       = jam_rst_q;
      res_valid     = res_valid_q;
      res_min       = res_min_q;
      res_cnt       = res_cnt_q;
      err_len       = err_q;
      Cost          = cost_q[{W, J}];
   end
endmodule

// File: tb/tb_jam_cost_loader.sv
// Randomized bench for jam_cost_loader: a frame-level reference model tracks the table,
// load progress and captured result, and a stub solver answers once released.
module tb_jam_cost_loader;
   logic       CLK;
   logic       RST;
   logic [2:0] W, J;
   logic [6:0] Cost;
   logic       jam_rst, jam_valid;
   logic [9:0] jam_min;
   logic [3:0] jam_cnt;
   logic       res_valid;
   logic [9:0] res_min;
   logic [3:0] res_cnt;
   logic       busy, err_len;

   jam_cost_loader_if #(.COST_W(7)) host_if ();

   jam_cost_loader #(.COST_W(7), .N(8)) dut (
      .CLK(CLK), .RST(RST), .host(host_if.slave),
      .W(W), .J(J), .Cost(Cost), .jam_rst(jam_rst),
      .jam_valid(jam_valid), .jam_min(jam_min), .jam_cnt(jam_cnt),
      .res_valid(res_valid), .res_min(res_min), .res_cnt(res_cnt),
      .busy(busy), .err_len(err_len)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef enum {M_LOAD, M_RUN, M_DONE} mode_e;

   int         n_checks = 0;
   int         n_errors = 0;
   mode_e      mode;
   int         m_idx;
   logic [6:0] m_tbl [64];
   bit         m_wr  [64];
   bit         m_rv, m_err;
   logic [9:0] m_min;
   logic [3:0] m_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: compare every output with the model, advance the model with the driven inputs, step.
   task automatic cycle();
      int a;
      if ($urandom % 4 == 0) {W, J} = 6'(m_idx);
      else {W, J} = 6'($urandom);
      #2;
      a = int'({W, J});
      check("in_ready", host_if.in_ready, mode != M_RUN);
      check("busy", busy, mode == M_RUN);
      check("jam_rst", jam_rst, mode == M_LOAD);
      check("res_valid", res_valid, m_rv);
      check("res_min", res_min, m_min);
      check("res_cnt", res_cnt, m_cnt);
      check("err_len", err_len, m_err);
      if (m_wr[a]) check("cost", Cost, m_tbl[a]);
      if (RST) begin
         mode = M_LOAD; m_idx = 0; m_rv = 0; m_min = 0; m_cnt = 0; m_err = 0;
      end else if (mode != M_RUN) begin
         if (host_if.in_valid) begin
            m_tbl[m_idx] = host_if.in_data;
            m_wr[m_idx]  = 1;
            m_rv = 0;
            if (host_if.in_last && m_idx == 63) begin
               m_idx = 0; mode = M_RUN;
            end else if (host_if.in_last || m_idx == 63) begin
               m_err = 1; m_idx = 0; mode = M_LOAD;
            end else begin
               m_idx++; mode = M_LOAD;
            end
         end
      end else if (jam_valid) begin
         m_rv = 1; m_min = jam_min; m_cnt = jam_cnt; mode = M_DONE;
      end
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [6:0] beat_data(input int kind, input int i);
      case (kind)
         0:       return 7'(i);
         2:       return 7'd7;
         3:       return ((i / 8) == (i % 8)) ? 7'd0 : 7'd100;
         default: return 7'($urandom);
      endcase
   endfunction

   task automatic send_frame(input int kind, input int nbeats, input int last_at, input bit toggle);
      for (int i = 0; i < nbeats; i++) begin
         if (toggle) begin
            host_if.in_valid = 0;
            cycle();
         end
         host_if.in_valid = 1;
         host_if.in_data  = beat_data(kind, i % 64);
         host_if.in_last  = (i + 1 == last_at);
         jam_valid = ($urandom % 4 == 0);
         jam_min   = 10'($urandom);
         jam_cnt   = 4'($urandom);
         cycle();
      end
      host_if.in_valid = 0;
      host_if.in_last  = 0;
      jam_valid = 0;
   endtask

   // Stub solver: idles a random time (host noise ignored), optionally pulses RST, then reports.
   task automatic run_solver(input logic [9:0] mn, input logic [3:0] cn, input int rst_at);
      int n = $urandom_range(3, 25);
      for (int k = 0; k < n; k++) begin
         host_if.in_valid = (rst_at < 0) ? 1'($urandom) : 1'b0;
         host_if.in_data  = 7'($urandom);
         host_if.in_last  = 1'($urandom);
         RST = (k == rst_at);
         cycle();
      end
      RST = 0;
      host_if.in_valid = 0;
      host_if.in_last  = 0;
      jam_valid = 1; jam_min = mn; jam_cnt = cn;
      cycle();
      jam_valid = 0;
   endtask

   task automatic hold(input int n);
      for (int k = 0; k < n; k++) begin
         host_if.in_valid = 0;
         jam_valid = ($urandom % 8 == 0);
         jam_min   = 10'($urandom);
         jam_cnt   = 4'($urandom);
         cycle();
      end
      jam_valid = 0;
   endtask

   initial begin
      mode = M_LOAD; m_idx = 0; m_rv = 0; m_err = 0; m_min = 0; m_cnt = 0;
      for (int i = 0; i < 64; i++) m_wr[i] = 0;
      RST = 1; W = 0; J = 0;
      host_if.in_valid = 0; host_if.in_data = 0; host_if.in_last = 0;
      jam_valid = 0; jam_min = 0; jam_cnt = 0;
      repeat (2) @(posedge CLK);
      #1;
      cycle();
      RST = 0;

      // Ramp table, then direct lookup of (3,5).
      send_frame(0, 64, 64, 0);
      check("busy_after_64", busy, 1);
      W = 3; J = 5;
      #1;
      check("cost_3_5", Cost, 29);
      run_solver(10'($urandom), 4'($urandom), -1);
      hold(20);

      // Diagonal-zero table; result must hold for a long idle stretch.
      send_frame(3, 64, 64, 0);
      run_solver(10'd0, 4'd1, -1);
      hold(1000);
      check("diag_res_min", res_min, 0);
      check("diag_res_cnt", res_cnt, 1);

      // Early in_last on beat 10, then a good frame.
      send_frame(1, 10, 10, 0);
      check("err_short", err_len, 1);
      hold(3);
      send_frame(1, 64, 64, 0);
      run_solver(10'($urandom), 4'($urandom), -1);

      // 64 beats without in_last, then the next beat starts a fresh frame.
      send_frame(1, 64, 0, 0);
      send_frame(1, 64, 64, 0);
      run_solver(10'($urandom), 4'($urandom), -1);
      hold(5);

      // New frame from DONE with gappy valid; all-7 table.
      send_frame(2, 64, 64, 1);
      run_solver(10'd56, 4'd8, -1);
      hold(50);
      check("all7_res_min", res_min, 56);

      // RST in the middle of a run, then a clean reload.
      send_frame(1, 64, 64, 0);
      run_solver(10'($urandom), 4'($urandom), 2);
      hold(5);
      send_frame(1, 64, 64, 0);
      run_solver(10'($urandom), 4'($urandom), -1);
      hold(5);

      // Single-beat frame from DONE.
      send_frame(1, 1, 1, 0);
      hold(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
